// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional feature macro used by this block: SERIAL_SUB_OVERFLOW_EN.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int MAX_WIDTH = 32;

   // Width of the bit counter; it only has to reach WIDTH-1.
   function automatic int count_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The ov signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bi;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             ov;
`endif

   modport master (
      output start, a, b, bi,
      input  busy, done, d, bo
`ifdef SERIAL_SUB_OVERFLOW_EN
      , input ov
`endif
   );

   modport slave (
      input  start, a, b, bi,
      output busy, done, d, bo
`ifdef SERIAL_SUB_OVERFLOW_EN
      , output ov
`endif
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor_1bit.sv
// Single-bit combinational full subtractor: diff = x - y - bin.
module full_subtractor_1bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = a - b - bi, one bit per clock, LSB first.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered two's-complement overflow output ov.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);

   localparam int CNT_W = count_width(WIDTH);

   state_t            state;
   state_t            next_state;
   logic [WIDTH-1:0]  a_sr;
   logic [WIDTH-1:0]  b_sr;
   logic [WIDTH-1:0]  res_sr;
   logic [WIDTH-1:0]  res_next;
   logic              borrow;
   logic [CNT_W-1:0]  count;
   logic              last_bit;
   logic              diff_bit;
   logic              next_borrow;
   logic              busy_q;
   logic              done_q;
   logic [WIDTH-1:0]  d_q;
   logic              bo_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic              ov_q;
`endif

   full_subtractor_1bit u_cell (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (borrow),
      .diff (diff_bit),
      .bout (next_borrow)
   );

   assign last_bit = (count == CNT_W'(WIDTH - 1));
   assign res_next = {diff_bit, res_sr[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = SHIFT;
         SHIFT:   if (last_bit)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath and registered outputs; the result is published on the last SHIFT edge
   // so d/bo are already valid in the cycle done is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         count  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         d_q    <= '0;
         bo_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         ov_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sr   <= bus.a;
                  b_sr   <= bus.b;
                  borrow <= bus.bi;
                  res_sr <= '0;
                  count  <= '0;
                  busy_q <= 1'b1;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               borrow <= next_borrow;
               count  <= count + CNT_W'(1);
               if (last_bit) begin
                  d_q    <= res_next;
                  bo_q   <= next_borrow;
                  done_q <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  // borrow still holds the borrow into the MSB during the last bit.
                  ov_q   <= borrow ^ next_borrow;
`endif
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.d    = d_q;
   assign bus.bo   = bo_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
   assign bus.ov   = ov_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4); checks ov too when
// SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             bi;
      logic [WIDTH-1:0] exp_d;
      logic             exp_bo;
      logic             exp_ov;
   } vec_t;

   vec_t vecs [9];

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic void ref_model(input int a, input int b, input int bi,
                                     output logic [WIDTH-1:0] d, output logic bo, output logic ov);
      int diff;
      int sa;
      int sb;
      int sdiff;
      diff  = a - b - bi;
      d     = WIDTH'(diff);
      bo    = (a < b + bi);
      sa    = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
      sb    = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
      sdiff = sa - sb - bi;
      ov    = (sdiff < -(1 << (WIDTH - 1))) || (sdiff > (1 << (WIDTH - 1)) - 1);
   endfunction

   // One full operation: start pulse, optional operand scrambling after capture,
   // bounded wait for done, result and return-to-idle checks.
   task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                                 input bit scramble, input string name,
                                 input logic [WIDTH-1:0] exp_d, input logic exp_bo, input logic exp_ov);
      int lat;
      bit found;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bi    = bi;
      @(negedge clk);
      bus.start = 1'b0;
      check_output({name, " busy after start"}, bus.busy, 1);
      check_output({name, " done after start"}, bus.done, 0);
      if (scramble) begin
         bus.a  = WIDTH'($urandom);
         bus.b  = WIDTH'($urandom);
         bus.bi = 1'($urandom);
      end
      lat   = 0;
      found = 1'b0;
      while (lat < 20 && !found) begin
         @(negedge clk);
         lat++;
         if (bus.done === 1'b1) found = 1'b1;
      end
      check_output({name, " done seen"}, found, 1);
      if (found) begin
         check_output({name, " latency"}, lat, WIDTH);
         check_output({name, " d"}, bus.d, exp_d);
         check_output({name, " bo"}, bus.bo, exp_bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
         check_output({name, " ov"}, bus.ov, exp_ov);
`endif
         @(negedge clk);
         check_output({name, " done pulse ends"}, bus.done, 0);
         check_output({name, " busy ends"}, bus.busy, 0);
         check_output({name, " d held"}, bus.d, exp_d);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] rd;
      logic             rbo;
      logic             rov;
      int               ra;
      int               rb;
      int               rbi;

      vecs[0] = '{a: 4'b0110, b: 4'b0011, bi: 1'b0, exp_d: 4'b0011, exp_bo: 1'b0, exp_ov: 1'b0};
      vecs[1] = '{a: 4'b0110, b: 4'b1001, bi: 1'b0, exp_d: 4'b1101, exp_bo: 1'b1, exp_ov: 1'b1};
      vecs[2] = '{a: 4'b0000, b: 4'b0000, bi: 1'b1, exp_d: 4'b1111, exp_bo: 1'b1, exp_ov: 1'b0};
      vecs[3] = '{a: 4'b0111, b: 4'b1111, bi: 1'b0, exp_d: 4'b1000, exp_bo: 1'b1, exp_ov: 1'b1};
      vecs[4] = '{a: 4'b0011, b: 4'b0001, bi: 1'b0, exp_d: 4'b0010, exp_bo: 1'b0, exp_ov: 1'b0};
      vecs[5] = '{a: 4'b1111, b: 4'b0001, bi: 1'b0, exp_d: 4'b1110, exp_bo: 1'b0, exp_ov: 1'b0};
      vecs[6] = '{a: 4'b1111, b: 4'b1111, bi: 1'b1, exp_d: 4'b1111, exp_bo: 1'b1, exp_ov: 1'b0};
      vecs[7] = '{a: 4'b0000, b: 4'b1111, bi: 1'b0, exp_d: 4'b0001, exp_bo: 1'b1, exp_ov: 1'b0};
      vecs[8] = '{a: 4'b1000, b: 4'b0001, bi: 1'b0, exp_d: 4'b0111, exp_bo: 1'b0, exp_ov: 1'b1};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bi    = 1'b0;

      @(negedge clk);
      check_output("reset busy", bus.busy, 0);
      check_output("reset done", bus.done, 0);
      check_output("reset d", bus.d, 0);
      check_output("reset bo", bus.bo, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check_output("reset ov", bus.ov, 0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].bi, 1'b0, $sformatf("vec%0d", i),
                        vecs[i].exp_d, vecs[i].exp_bo, vecs[i].exp_ov);
      end

      apply_stimulus(4'b0110, 4'b0011, 1'b0, 1'b1, "operands changed mid-shift",
                     4'b0011, 1'b0, 1'b0);

      // start held high: a new operation every WIDTH+2 cycles with one idle cycle between.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'b1111;
      bus.b     = 4'b0001;
      bus.bi    = 1'b0;
      for (int idx = 0; idx < 18; idx++) begin
         @(negedge clk);
         check_output($sformatf("b2b done idx%0d", idx), bus.done, ((idx % 6) == 4) ? 1 : 0);
         check_output($sformatf("b2b busy idx%0d", idx), bus.busy, ((idx % 6) != 5) ? 1 : 0);
         if ((idx % 6) == 4) begin
            check_output($sformatf("b2b d idx%0d", idx), bus.d, 4'b1110);
            check_output($sformatf("b2b bo idx%0d", idx), bus.bo, 0);
         end
         if (idx == 17) bus.start = 1'b0;
      end

      // Reset two cycles into SHIFT discards the operation and clears held results.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'b0101;
      bus.b     = 4'b0010;
      bus.bi    = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("mid-shift reset busy", bus.busy, 0);
      check_output("mid-shift reset done", bus.done, 0);
      check_output("mid-shift reset d", bus.d, 0);
      check_output("mid-shift reset bo", bus.bo, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check_output("mid-shift reset ov", bus.ov, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_output($sformatf("post-reset quiet done %0d", i), bus.done, 0);
         check_output($sformatf("post-reset quiet busy %0d", i), bus.busy, 0);
      end
      apply_stimulus(4'b0101, 4'b0010, 1'b0, 1'b0, "after reset", 4'b0011, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra  = int'($urandom_range(0, (1 << WIDTH) - 1));
         rb  = int'($urandom_range(0, (1 << WIDTH) - 1));
         rbi = int'($urandom_range(0, 1));
         ref_model(ra, rb, rbi, rd, rbo, rov);
         apply_stimulus(WIDTH'(ra), WIDTH'(rb), 1'(rbi), 1'($urandom_range(0, 1)),
                        $sformatf("rand%0d a=%0h b=%0h bi=%0d", i, ra, rb, rbi), rd, rbo, rov);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
